vga_sync_gen: RTL

- Raster timing generator directly upstream of the animation/pixel-colour stage.
- Produces the pixel coordinates x/y consumed by the frame ROMs.
- Produces sync and blanking strobes, delayed to line up with the colour stage's registered output.
- Also emits a one-cycle frame_start strobe that downstream frame sequencers use in place of free-running dividers.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/sync_delay.sv | 48 ++++
 rtl/vga_sync_gen.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
// Purpose : shared raster-timing constants and types for the VGA sync path.
//           Defaults describe 1280x1024@60 (108 MHz pixel clock). Derived
//           sync window boundaries are half-open: [START, END).
// Ports   : none (package).
// Config  : no macros.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

   // 12-bit unsigned raster coordinate, shared with the frame ROM address path
   typedef logic [11:0] coord_t;

   localparam int H_ACTIVE   = 1280;
   localparam int H_FP       = 48;
   localparam int H_SYNC     = 112;
   localparam int H_BP       = 248;
   localparam int V_ACTIVE   = 1024;
   localparam int V_FP       = 1;
   localparam int V_SYNC     = 3;
   localparam int V_BP       = 38;
   localparam bit HS_POL     = 1'b1;
   localparam bit VS_POL     = 1'b1;
   localparam int PIPE_DELAY = 2;

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 1688
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 1066
   localparam int HS_START = H_ACTIVE + H_FP;                   // 1328
   localparam int HS_END   = HS_START + H_SYNC;                 // 1440
   localparam int VS_START = V_ACTIVE + V_FP;                   // 1025
   localparam int VS_END   = VS_START + V_SYNC;                 // 1028

   // Map an asserted/deasserted decode onto the physical sync level
   function automatic logic sync_level(input logic asserted, input logic pol);
      return asserted ? pol : ~pol;
   endfunction

endpackage : vga_timing_pkg

// File: rtl/sync_delay.sv
// ----------------------------------------------------------------------------
// sync_delay
// Purpose : WIDTH-bit, DEPTH-stage shift register used to align strobes with
//           a downstream registered pipeline. DEPTH=0 is a plain wire.
// Ports   : clk_i      clock
//           rst_i      asynchronous active-high reset
//           rst_val_i  value every stage takes while reset is asserted
//           d_i        input word
//           q_o        input word delayed by DEPTH cycles
// Config  : no macros.
// ----------------------------------------------------------------------------
module sync_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] rst_val_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   if (DEPTH == 0) begin : g_bypass
      // Clock and reset have no role without storage
      logic unused_s;
      assign unused_s = ^{clk_i, rst_i, rst_val_i};
      assign q_o      = d_i;
   end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift chain; stage 0 captures the input, last stage drives the output
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
               stage_q[i] <= rst_val_i;
            end
         end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
               stage_q[i] <= stage_q[i-1];
            end
         end
      end

      assign q_o = stage_q[DEPTH-1];
   end

endmodule : sync_delay

// File: rtl/vga_sync_gen.sv
// ----------------------------------------------------------------------------
// vga_sync_gen
// Purpose : raster timing generator. Produces x/y for the frame ROMs, and
//           sync/blank strobes delayed by PIPE_DELAY so they line up with the
//           colour stage's registered output. Also emits undelayed line and
//           frame start pulses for downstream sequencers.
// Ports   : vgaClk       pixel clock
//           reset        asynchronous active-high reset
//           x, y         registered raster counters (12-bit)
//           video_on     active-region flag, PIPE_DELAY cycles late
//           hsync/vsync  sync strobes, PIPE_DELAY cycles late, HS_POL/VS_POL
//           line_start   one-cycle pulse while x==0
//           frame_start  one-cycle pulse while x==0 and y==0
//           frame_count  frames since reset (FRAME_COUNT_EN only)
// Config  : `define FRAME_COUNT_EN adds the frame_count port and counter.
// ----------------------------------------------------------------------------
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
   parameter int H_FP       = vga_timing_pkg::H_FP,
   parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
   parameter int H_BP       = vga_timing_pkg::H_BP,
   parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
   parameter int V_FP       = vga_timing_pkg::V_FP,
   parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
   parameter int V_BP       = vga_timing_pkg::V_BP,
   parameter bit HS_POL     = vga_timing_pkg::HS_POL,
   parameter bit VS_POL     = vga_timing_pkg::VS_POL,
   parameter int PIPE_DELAY = vga_timing_pkg::PIPE_DELAY
) (
   input  logic        vgaClk,
   input  logic        reset,
   output coord_t      x,
   output coord_t      y,
   output logic        video_on,
   output logic        hsync,
   output logic        vsync,
   output logic        line_start,
   output logic        frame_start
`ifdef FRAME_COUNT_EN
   ,
   output logic [15:0] frame_count
`endif
);

   localparam int     H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int     V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam coord_t X_LAST   = coord_t'(H_TOTAL - 1);
   localparam coord_t Y_LAST   = coord_t'(V_TOTAL - 1);
   localparam coord_t X_ACT    = coord_t'(H_ACTIVE);
   localparam coord_t Y_ACT    = coord_t'(V_ACTIVE);
   localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

   if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
      $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed 4096");
   end
   if (PIPE_DELAY < 0) begin : g_bad_delay
      $error("vga_sync_gen: PIPE_DELAY must be non-negative");
   end

   // arm_q is low only for the first clock after reset release. That clock
   // holds the counters at 0,0 while the registered pulses load, so
   // frame_start is visible together with x=y=0 in the first full cycle.
   logic   arm_q;
   coord_t x_q, x_d;
   coord_t y_q, y_d;
   logic   line_start_q, line_start_d;
   logic   frame_start_q, frame_start_d;

   // Next-state raster counters and the start pulses that follow them
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (!arm_q) begin
         x_d = x_q;
         y_d = y_q;
      end else if (x_q == X_LAST) begin
         x_d = 12'd0;
         if (y_q == Y_LAST) begin
            y_d = 12'd0;
         end else begin
            y_d = y_q + 12'd1;
         end
      end else begin
         x_d = x_q + 12'd1;
         y_d = y_q;
      end
      line_start_d  = (x_d == 12'd0);
      frame_start_d = (x_d == 12'd0) && (y_d == 12'd0);
   end

   // Counter and pulse registers
   always_ff @(posedge vgaClk or posedge reset) begin
      if (reset) begin
         arm_q         <= 1'b0;
         x_q           <= 12'd0;
         y_q           <= 12'd0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         arm_q         <= 1'b1;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Raw decodes from the registered counters. The priming cycle feeds the
   // inactive state so no strobe is ever emitted for that duplicate 0,0.
   logic       act_s, hs_on_s, vs_on_s;
   logic [2:0] pipe_in_s, pipe_out_s, pipe_rst_s;

   assign act_s      = arm_q && (x_q < X_ACT) && (y_q < Y_ACT);
   assign hs_on_s    = arm_q && (x_q >= HS_START) && (x_q < HS_END);
   assign vs_on_s    = arm_q && (y_q >= VS_START) && (y_q < VS_END);
   assign pipe_in_s  = {act_s, sync_level(hs_on_s, HS_POL), sync_level(vs_on_s, VS_POL)};
   assign pipe_rst_s = {1'b0, ~HS_POL, ~VS_POL};

   sync_delay #(
      .WIDTH (3),
      .DEPTH (PIPE_DELAY)
   ) u_sync_delay (
      .clk_i     (vgaClk),
      .rst_i     (reset),
      .rst_val_i (pipe_rst_s),
      .d_i       (pipe_in_s),
      .q_o       (pipe_out_s)
   );

   assign x           = x_q;
   assign y           = y_q;
   assign video_on    = pipe_out_s[2];
   assign hsync       = pipe_out_s[1];
   assign vsync       = pipe_out_s[0];
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef FRAME_COUNT_EN
   // The first frame after reset is frame 0, so its pulse only arms the count.
   // The counter steps on the same edge that raises frame_start, so the new
   // value is already visible while the pulse is high.
   logic [15:0] frame_count_q, frame_count_d;
   logic        seen_q, seen_d;

   // Next frame count
   always_comb begin
      frame_count_d = frame_count_q;
      seen_d        = seen_q;
      if (frame_start_d) begin
         seen_d = 1'b1;
         if (seen_q) begin
            frame_count_d = frame_count_q + 16'd1;
         end else begin
            frame_count_d = frame_count_q;
         end
      end else begin
         frame_count_d = frame_count_q;
      end
   end

   // Frame counter registers
   always_ff @(posedge vgaClk or posedge reset) begin
      if (reset) begin
         frame_count_q <= 16'd0;
         seen_q        <= 1'b0;
      end else begin
         frame_count_q <= frame_count_d;
         seen_q        <= seen_d;
      end
   end

   assign frame_count = frame_count_q;
`else
   // Frame counter not built in this configuration
`endif

endmodule : vga_sync_gen
